// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if -- issue-stage pipeline bus.
//
// Carries the decode -> issue handshake with its instruction payload and the
// issue -> ALU handshake with the registered operands and control.
//   Upstream   : in_valid, in_ready, rs1/rs2 addr/data/used, pc, imm,
//                a_sel, b_sel, alu_op_in, rd_addr, rd_we
//   Downstream : out_valid, out_ready, a, b, store_data, alu_op, rd_q, rd_we_q
// Modports:
//   slave  : the issue stage (consumes the upstream payload, drives results)
//   master : the environment around it (decode plus the ALU stage)
interface alu_issue_stage_if;
    localparam int XLEN         = 32;
    localparam int ALU_OP_WIDTH = 4;

    // Upstream (decode) side
    logic                    in_valid;
    logic                    in_ready;
    logic [4:0]              rs1_addr;
    logic [4:0]              rs2_addr;
    logic [XLEN-1:0]         rs1_data;
    logic [XLEN-1:0]         rs2_data;
    logic                    rs1_used;
    logic                    rs2_used;
    logic [XLEN-1:0]         pc;
    logic [XLEN-1:0]         imm;
    logic                    a_sel;
    logic                    b_sel;
    logic [ALU_OP_WIDTH-1:0] alu_op_in;
    logic [4:0]              rd_addr;
    logic                    rd_we;

    // Downstream (ALU stage) side
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         a;
    logic [XLEN-1:0]         b;
    logic [XLEN-1:0]         store_data;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [4:0]              rd_q;
    logic                    rd_we_q;

    modport slave (
        input  in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data,
               rs1_used, rs2_used, pc, imm, a_sel, b_sel,
               alu_op_in, rd_addr, rd_we, out_ready,
        output in_ready, out_valid, a, b, store_data, alu_op, rd_q, rd_we_q
    );

    modport master (
        output in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data,
               rs1_used, rs2_used, pc, imm, a_sel, b_sel,
               alu_op_in, rd_addr, rd_we, out_ready,
        input  in_ready, out_valid, a, b, store_data, alu_op, rd_q, rd_we_q
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage -- single-entry issue register in front of the ALU.
//
// Accepts one decoded instruction per cycle, resolves its source operands
// against the EX/MEM and MEM/WB producers, and presents the selected ALU
// operands one cycle after accept.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       upstream/downstream handshakes and payload
//   exm_rd/we/load/result   producer currently in EX/MEM
//   mwb_rd/we/result        producer currently in MEM/WB
//   flush             drop the held and the incoming instruction
//   hazard_stall      combinational; issue blocked by a data hazard
//
// Build option: define ALU_ISSUE_FORWARDING_EN to enable operand forwarding
// (stall only on load-use). Without it, no forwarding is done and any match
// against an in-flight producer stalls issue.
module alu_issue_stage (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_issue_stage_if.slave      bus,
    input  logic [4:0]            exm_rd,
    input  logic                  exm_we,
    input  logic                  exm_load,
    input  logic [31:0]           exm_result,
    input  logic [4:0]            mwb_rd,
    input  logic                  mwb_we,
    input  logic [31:0]           mwb_result,
    input  logic                  flush,
    output logic                  hazard_stall
);
    localparam int XLEN         = 32;
    localparam int ALU_OP_WIDTH = 4;

    // Producer match per source; register 0 never matches.
    logic ex_hit1, ex_hit2, mw_hit1, mw_hit2;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    assign ex_hit1 = bus.rs1_used && exm_we && (exm_rd == bus.rs1_addr) && (bus.rs1_addr != 5'd0);
    assign ex_hit2 = bus.rs2_used && exm_we && (exm_rd == bus.rs2_addr) && (bus.rs2_addr != 5'd0);
    assign mw_hit1 = bus.rs1_used && mwb_we && (mwb_rd == bus.rs1_addr) && (bus.rs1_addr != 5'd0);
    assign mw_hit2 = bus.rs2_used && mwb_we && (mwb_rd == bus.rs2_addr) && (bus.rs2_addr != 5'd0);

`ifdef ALU_ISSUE_FORWARDING_EN
    // EX/MEM is the younger producer, so it wins over MEM/WB.
    assign fwd_rs1 = ex_hit1 ? exm_result : (mw_hit1 ? mwb_result : bus.rs1_data);
    assign fwd_rs2 = ex_hit2 ? exm_result : (mw_hit2 ? mwb_result : bus.rs2_data);
    // A load in EX/MEM has no result yet: only that case must wait.
    assign hazard_stall = bus.in_valid && exm_load && (ex_hit1 || ex_hit2);
`else
    assign fwd_rs1 = bus.rs1_data;
    assign fwd_rs2 = bus.rs2_data;
    assign hazard_stall = bus.in_valid && (ex_hit1 || ex_hit2 || mw_hit1 || mw_hit2);

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{exm_load, exm_result, mwb_result};
`endif

    // Pipeline register state
    logic                    valid_q,  valid_d;
    logic [XLEN-1:0]         a_q,      a_d;
    logic [XLEN-1:0]         b_q,      b_d;
    logic [XLEN-1:0]         sd_q,     sd_d;
    logic [ALU_OP_WIDTH-1:0] op_q,     op_d;
    logic [4:0]              rd_reg_q, rd_reg_d;
    logic                    we_q,     we_d;

    logic in_ready;
    logic accept;

    assign in_ready     = (!valid_q || bus.out_ready) && !hazard_stall;
    assign accept       = bus.in_valid && in_ready && !flush;
    assign bus.in_ready = in_ready;

    always_comb begin
        valid_d  = valid_q;
        a_d      = a_q;
        b_d      = b_q;
        sd_d     = sd_q;
        op_d     = op_q;
        rd_reg_d = rd_reg_q;
        we_d     = we_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            // Also covers consume-and-accept in the same cycle: no bubble.
            valid_d  = 1'b1;
            a_d      = bus.a_sel ? bus.pc  : fwd_rs1;
            b_d      = bus.b_sel ? bus.imm : fwd_rs2;
            sd_d     = fwd_rs2;
            op_d     = bus.alu_op_in;
            rd_reg_d = bus.rd_addr;
            we_d     = bus.rd_we;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sd_q     <= '0;
            op_q     <= '0;
            rd_reg_q <= '0;
            we_q     <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sd_q     <= sd_d;
            op_q     <= op_d;
            rd_reg_q <= rd_reg_d;
            we_q     <= we_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.a          = a_q;
    assign bus.b          = b_q;
    assign bus.store_data = sd_q;
    assign bus.alu_op     = op_q;
    assign bus.rd_q       = rd_reg_q;
    assign bus.rd_we_q    = we_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage -- self-checking bench for alu_issue_stage.
// Reference model tracks the held instruction from the handshake rules;
// directed sequences pin its expectations with literal values, then a
// randomized phase exercises the block against the model every cycle.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_stage_if bus ();

    logic [4:0]  exm_rd, mwb_rd;
    logic        exm_we, exm_load, mwb_we, flush;
    logic [31:0] exm_result, mwb_result;
    logic        hazard_stall;

    alu_issue_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .exm_rd       (exm_rd),
        .exm_we       (exm_we),
        .exm_load     (exm_load),
        .exm_result   (exm_result),
        .mwb_rd       (mwb_rd),
        .mwb_we       (mwb_we),
        .mwb_result   (mwb_result),
        .flush        (flush),
        .hazard_stall (hazard_stall)
    );

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_valid;
    logic [31:0] m_a, m_b, m_sd;
    logic [3:0]  m_op;
    logic [4:0]  m_rd;
    logic        m_we;

    // Producer value a source sees, in priority order.
    function automatic logic [31:0] m_src(input logic used, input logic [4:0] idx,
                                          input logic [31:0] data);
        logic [31:0] v;
        v = data;
`ifdef ALU_ISSUE_FORWARDING_EN
        if (used && idx != 5'd0) begin
            if (exm_we && exm_rd == idx)      v = exm_result;
            else if (mwb_we && mwb_rd == idx) v = mwb_result;
        end
`endif
        return v;
    endfunction

    function automatic logic m_stall();
        logic [4:0] idx [2];
        logic       used [2];
        logic       hit_ex, hit_mw;
        idx[0] = bus.rs1_addr; used[0] = bus.rs1_used;
        idx[1] = bus.rs2_addr; used[1] = bus.rs2_used;
        hit_ex = 1'b0;
        hit_mw = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (used[s] && idx[s] != 5'd0) begin
                if (exm_we && exm_rd == idx[s]) hit_ex = 1'b1;
                if (mwb_we && mwb_rd == idx[s]) hit_mw = 1'b1;
            end
        end
        if (!bus.in_valid) return 1'b0;
`ifdef ALU_ISSUE_FORWARDING_EN
        return hit_ex && exm_load;
`else
        return hit_ex || hit_mw;
`endif
    endfunction

    function automatic logic m_ready();
        return (!m_valid || bus.out_ready) && !m_stall();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_a <= '0; m_b <= '0; m_sd <= '0;
            m_op <= '0; m_rd <= '0; m_we <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (bus.in_valid && m_ready()) begin
            m_valid <= 1'b1;
            m_a  <= bus.a_sel ? bus.pc  : m_src(bus.rs1_used, bus.rs1_addr, bus.rs1_data);
            m_b  <= bus.b_sel ? bus.imm : m_src(bus.rs2_used, bus.rs2_addr, bus.rs2_data);
            m_sd <= m_src(bus.rs2_used, bus.rs2_addr, bus.rs2_data);
            m_op <= bus.alu_op_in;
            m_rd <= bus.rd_addr;
            m_we <= bus.rd_we;
        end else if (bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        #2;
        if (cmp_en && rst_n) begin
            chk("m_out_valid", bus.out_valid, m_valid);
            chk("m_hazard_stall", hazard_stall, m_stall());
            chk("m_in_ready", bus.in_ready, m_ready());
            if (m_valid) begin
                chk("m_a", bus.a, m_a);
                chk("m_b", bus.b, m_b);
                chk("m_store_data", bus.store_data, m_sd);
                chk("m_alu_op", bus.alu_op, m_op);
                chk("m_rd_q", bus.rd_q, m_rd);
                chk("m_rd_we_q", bus.rd_we_q, m_we);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        bus.in_valid = 1'b0; bus.rs1_addr = '0; bus.rs2_addr = '0;
        bus.rs1_data = '0; bus.rs2_data = '0; bus.rs1_used = 1'b0; bus.rs2_used = 1'b0;
        bus.pc = '0; bus.imm = '0; bus.a_sel = 1'b0; bus.b_sel = 1'b0;
        bus.alu_op_in = '0; bus.rd_addr = '0; bus.rd_we = 1'b0; bus.out_ready = 1'b1;
        exm_rd = '0; exm_we = 1'b0; exm_load = 1'b0; exm_result = '0;
        mwb_rd = '0; mwb_we = 1'b0; mwb_result = '0; flush = 1'b0;
    endtask

    task automatic rand_inputs();
        bus.in_valid  = ($urandom_range(0, 9) < 7);
        bus.rs1_addr  = 5'($urandom_range(0, 3));
        bus.rs2_addr  = 5'($urandom_range(0, 3));
        bus.rs1_data  = $urandom;
        bus.rs2_data  = $urandom;
        bus.rs1_used  = 1'($urandom_range(0, 1));
        bus.rs2_used  = 1'($urandom_range(0, 1));
        bus.pc        = $urandom;
        bus.imm       = $urandom;
        bus.a_sel     = 1'($urandom_range(0, 1));
        bus.b_sel     = 1'($urandom_range(0, 1));
        bus.alu_op_in = 4'($urandom_range(0, 15));
        bus.rd_addr   = 5'($urandom_range(0, 31));
        bus.rd_we     = 1'($urandom_range(0, 1));
        bus.out_ready = ($urandom_range(0, 9) < 7);
        exm_rd        = 5'($urandom_range(0, 3));
        exm_we        = 1'($urandom_range(0, 1));
        exm_load      = ($urandom_range(0, 3) == 0);
        exm_result    = $urandom;
        mwb_rd        = 5'($urandom_range(0, 3));
        mwb_we        = 1'($urandom_range(0, 1));
        mwb_result    = $urandom;
        flush         = ($urandom_range(0, 19) == 0);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #3;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_a", bus.a, 0);
        chk("reset_b", bus.b, 0);
        chk("reset_store_data", bus.store_data, 0);
        chk("reset_alu_op", bus.alu_op, 0);
        chk("reset_rd_q", bus.rd_q, 0);
        chk("reset_rd_we_q", bus.rd_we_q, 0);
        @(negedge clk); @(negedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        // x0 is never a producer match
        @(negedge clk);
        idle();
        bus.in_valid = 1'b1; bus.rs1_used = 1'b1; bus.rs1_addr = 5'd0; bus.rs1_data = '0;
        exm_rd = 5'd0; exm_we = 1'b1; exm_result = 32'hDEAD;
        bus.b_sel = 1'b1; bus.imm = 32'h4; bus.alu_op_in = 4'h3; bus.rd_addr = 5'd9; bus.rd_we = 1'b1;
        #3;
        chk("x0_stall", hazard_stall, 0);
        chk("x0_in_ready", bus.in_ready, 1);
        @(posedge clk); #3;
        chk("x0_out_valid", bus.out_valid, 1);
        chk("x0_a", bus.a, 0);
        chk("x0_b", bus.b, 32'h4);
        chk("x0_alu_op", bus.alu_op, 4'h3);
        chk("x0_rd_q", bus.rd_q, 5'd9);
        chk("x0_rd_we_q", bus.rd_we_q, 1);

        // rs1 matched in both EX/MEM and MEM/WB
        @(negedge clk);
        idle();
        bus.in_valid = 1'b1; bus.rs1_used = 1'b1; bus.rs1_addr = 5'd5; bus.rs1_data = 32'h5;
        exm_rd = 5'd5; exm_we = 1'b1; exm_result = 32'h10;
        mwb_rd = 5'd5; mwb_we = 1'b1; mwb_result = 32'h20;
`ifdef ALU_ISSUE_FORWARDING_EN
        #3 chk("fwd_ex_stall", hazard_stall, 0);
        @(posedge clk); #3 chk("fwd_ex_a", bus.a, 32'h10);
        @(negedge clk); exm_we = 1'b0;
        #3 chk("fwd_mw_stall", hazard_stall, 0);
        @(posedge clk); #3 chk("fwd_mw_a", bus.a, 32'h20);
`else
        #3 chk("nofwd_ex_stall", hazard_stall, 1);
        chk("nofwd_ex_in_ready", bus.in_ready, 0);
        @(posedge clk); #3 chk("nofwd_bubble", bus.out_valid, 0);
        @(negedge clk); exm_we = 1'b0;
        #3 chk("nofwd_mw_stall", hazard_stall, 1);
        @(posedge clk); #3 chk("nofwd_mw_out_valid", bus.out_valid, 0);
        @(negedge clk); mwb_we = 1'b0;
        #3 chk("nofwd_clear_stall", hazard_stall, 0);
        @(posedge clk); #3;
        chk("nofwd_out_valid", bus.out_valid, 1);
        chk("nofwd_a", bus.a, 32'h5);
`endif

        // load-use on rs2
        @(negedge clk);
        idle();
        bus.in_valid = 1'b1; bus.rs2_used = 1'b1; bus.rs2_addr = 5'd7; bus.rs2_data = 32'h77;
        exm_rd = 5'd7; exm_we = 1'b1; exm_load = 1'b1; exm_result = 32'hBAD;
        #3;
        chk("lu_stall", hazard_stall, 1);
        chk("lu_in_ready", bus.in_ready, 0);
        @(posedge clk); #3 chk("lu_bubble", bus.out_valid, 0);
        @(negedge clk);
        exm_we = 1'b0; exm_load = 1'b0; mwb_rd = 5'd7; mwb_we = 1'b1; mwb_result = 32'h700;
`ifdef ALU_ISSUE_FORWARDING_EN
        #3 chk("lu_mw_stall", hazard_stall, 0);
        @(posedge clk); #3;
        chk("lu_b", bus.b, 32'h700);
        chk("lu_store_data", bus.store_data, 32'h700);
`else
        #3 chk("lu_mw_stall", hazard_stall, 1);
        @(posedge clk); #3 chk("lu_mw_out_valid", bus.out_valid, 0);
        @(negedge clk); mwb_we = 1'b0;
        @(posedge clk); #3;
        chk("lu_b", bus.b, 32'h77);
        chk("lu_store_data", bus.store_data, 32'h77);
`endif

        // backpressure, then flush with a same-cycle incoming instruction
        @(negedge clk);
        idle();
        bus.in_valid = 1'b1; bus.a_sel = 1'b1; bus.pc = 32'h1000; bus.b_sel = 1'b1; bus.imm = 32'h8;
        @(posedge clk); #3 chk("bp_load_a", bus.a, 32'h1000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b0; bus.pc = 32'h2000 + 32'(i);
            #3 chk("bp_in_ready", bus.in_ready, 0);
            @(posedge clk); #3;
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_a", bus.a, 32'h1000);
            chk("bp_b", bus.b, 32'h8);
        end
        @(negedge clk);
        bus.out_ready = 1'b1; flush = 1'b1; bus.pc = 32'h3000;
        @(posedge clk); #3 chk("flush_out_valid", bus.out_valid, 0);
        @(negedge clk);
        idle();
        @(posedge clk); #3;
        chk("flush_dropped_valid", bus.out_valid, 0);
        chk("flush_dropped_a", bus.a, 32'h1000);

        // asynchronous reset while an instruction is held
        @(negedge clk);
        idle();
        bus.in_valid = 1'b1; bus.a_sel = 1'b1; bus.pc = 32'hABC;
        bus.b_sel = 1'b1; bus.imm = 32'h11; bus.out_ready = 1'b0;
        @(posedge clk); #3;
        chk("ar_held_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", bus.out_valid, 0);
        chk("ar_a", bus.a, 0);
        chk("ar_b", bus.b, 0);
        chk("ar_store_data", bus.store_data, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #3;
        chk("ar_first_accept_valid", bus.out_valid, 1);
        chk("ar_first_accept_a", bus.a, 32'hABC);

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rand_inputs();
        end
        @(negedge clk);
        idle();
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
